// File: rtl/stimulus_controller.sv
// stimulus_controller: conditions raw pet/feed/poke/noise pins into single-cycle
// stress/pleasure inc/dec pulses, with refractory hold-off and periodic decay.
module stimulus_controller #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REFRACTORY      = 8,
    parameter int DECAY_PERIOD    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] stim_in,
    input  logic       asleep,
    input  logic [1:0] stress_indicator,
    output logic       stress_inc,
    output logic       stress_dec,
    output logic       pleasure_inc,
    output logic       pleasure_dec,
    output logic [3:0] drop_count
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(REFRACTORY + 1);
    localparam int TW = $clog2(DECAY_PERIOD);

    typedef enum logic [2:0] {IDLE, APPLY, APPLY2, HOLDOFF, DECAY} state_t;

    state_t           state;
    logic [3:0]       s1, s, deb, pending, acc, ev, cand, sel, sleep_drop, clr, drops;
    logic [3:0][CW-1:0] c;
    logic [HW-1:0]    hcnt;
    logic [TW-1:0]    tcnt;
    logic             decay_pending, wrap, idle, dclr, dbl;
    logic [4:0]       dsum;
    logic [3:0]       drop_next;

    always_comb begin
        for (int i = 0; i < 4; i++)
            acc[i] = (s[i] != deb[i]) && (c[i] == CW'(DEBOUNCE_CYCLES - 1));
        ev         = acc & s;
        idle       = state == IDLE;
        // asleep: pet/feed are discarded at selection rather than applied
        cand       = asleep ? (pending & 4'b1100) : pending;
        sleep_drop = (idle && asleep) ? (pending & 4'b0011) : 4'b0000;
        sel        = cand[3] ? 4'b1000 : cand[2] ? 4'b0100 : cand[1] ? 4'b0010 :
                     cand[0] ? 4'b0001 : 4'b0000;
        clr        = idle ? (sel | sleep_drop) : 4'b0000;
        dclr       = idle && (sel == 4'b0000) && decay_pending;
        wrap       = tcnt == TW'(DECAY_PERIOD - 1);
        drops      = (ev & pending) | sleep_drop;
        dsum       = {1'b0, drop_count} + 5'($countones(drops));
        drop_next  = (dsum > 5'd15) ? 4'hf : dsum[3:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1            <= '0;
            s             <= '0;
            deb           <= '0;
            c             <= '0;
            pending       <= '0;
            decay_pending <= 1'b0;
            tcnt          <= '0;
            drop_count    <= '0;
        end else begin
            s1 <= stim_in;
            s  <= s1;
            deb <= deb ^ acc;
            for (int i = 0; i < 4; i++)
                c[i] <= (s[i] == deb[i] || acc[i]) ? '0 : c[i] + CW'(1);
            pending       <= (pending & ~clr) | (ev & ~pending);
            tcnt          <= wrap ? '0 : tcnt + TW'(1);
            decay_pending <= wrap | (decay_pending & ~dclr);
            drop_count    <= drop_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            hcnt         <= '0;
            dbl          <= 1'b0;
            stress_inc   <= 1'b0;
            stress_dec   <= 1'b0;
            pleasure_inc <= 1'b0;
            pleasure_dec <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel != 4'b0000) begin
                        state        <= APPLY;
                        dbl          <= asleep;
                        stress_inc   <= sel[3] | sel[2];
                        stress_dec   <= sel[0];
                        pleasure_inc <= sel[0] | sel[1];
                        pleasure_dec <= sel[3] & ~asleep;
                    end else if (decay_pending) begin
                        state        <= DECAY;
                        stress_dec   <= stress_indicator != 2'd0;
                        pleasure_dec <= ~asleep;
                    end
                end
                APPLY: begin
                    hcnt <= '0;
                    // asleep poke/noise keep stress_inc high for a second cycle
                    if (dbl) begin
                        state <= APPLY2;
                    end else begin
                        state        <= HOLDOFF;
                        stress_inc   <= 1'b0;
                        stress_dec   <= 1'b0;
                        pleasure_inc <= 1'b0;
                        pleasure_dec <= 1'b0;
                    end
                end
                APPLY2: begin
                    state        <= HOLDOFF;
                    hcnt         <= '0;
                    stress_inc   <= 1'b0;
                    stress_dec   <= 1'b0;
                    pleasure_inc <= 1'b0;
                    pleasure_dec <= 1'b0;
                end
                HOLDOFF: begin
                    state <= (hcnt == HW'(REFRACTORY - 1)) ? IDLE : HOLDOFF;
                    hcnt  <= hcnt + HW'(1);
                end
                DECAY: begin
                    state        <= IDLE;
                    stress_dec   <= 1'b0;
                    pleasure_dec <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_stimulus_controller.sv
// tb_stimulus_controller: scoreboard bench; expected pulses (cycle, vector) are
// queued as stimulus is driven and matched against every nonzero output cycle.
module tb_stimulus_controller;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] stim;
    logic       asleep;
    logic [1:0] ind;
    logic       stress_inc, stress_dec, pleasure_inc, pleasure_dec;
    logic [3:0] drop_count;
    int         cyc = 0;
    int         n_vec = 0;
    int         n_err = 0;

    typedef struct {
        int         cyc;
        logic [3:0] vec;
    } exp_t;
    exp_t sb[$];

    stimulus_controller dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stim_in          (stim),
        .asleep           (asleep),
        .stress_indicator (ind),
        .stress_inc       (stress_inc),
        .stress_dec       (stress_dec),
        .pleasure_inc     (pleasure_inc),
        .pleasure_dec     (pleasure_dec),
        .drop_count       (drop_count)
    );

    always #5 clk = ~clk;

    // cyc counts rising edges since the last reset release
    always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic push(input int c, input logic [3:0] v);
        exp_t e;
        e.cyc = c;
        e.vec = v;
        sb.push_back(e);
    endtask

    // vec = {stress_inc, stress_dec, pleasure_inc, pleasure_dec}
    always @(negedge clk) begin
        logic [3:0] v;
        exp_t e;
        v = {stress_inc, stress_dec, pleasure_inc, pleasure_dec};
        if (rst_n && v != 4'b0000) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", 32'(v), 32'h0);
            end else begin
                e = sb.pop_front();
                check("pulse_vec", 32'(v), 32'(e.vec));
                check("pulse_cyc", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        stim  = 4'b0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outs", 32'({stress_inc, stress_dec, pleasure_inc, pleasure_dec}), 32'h0);
        check("rst_drop", 32'(drop_count), 32'h0);
        rst_n = 1'b1;
    endtask

    task automatic end_test(input int n);
        wait_cyc(n);
        check("missing_pulses", 32'(sb.size()), 32'h0);
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; stim = 4'b0000; asleep = 1'b0; ind = 2'd0;

        // idle: only the first decay pulse
        do_reset();
        push(17, 4'b0001);
        wait_cyc(3);
        check("idle_drop", 32'(drop_count), 32'h0);
        end_test(20);

        // 3-cycle pet glitch is filtered
        do_reset();
        wait_cyc(1); stim = 4'b0001;
        wait_cyc(4); stim = 4'b0000;
        push(17, 4'b0001);
        end_test(20);

        // pet held: pulse 6 edges after first sample, decay after hold-off
        do_reset();
        wait_cyc(1); stim = 4'b0001;
        push(8, 4'b0110); push(18, 4'b0001);
        end_test(25);

        // noise + pet together: noise first, pet R+2 cycles later, then decay
        do_reset();
        wait_cyc(1); stim = 4'b1001;
        push(8, 4'b1001); push(18, 4'b0110); push(28, 4'b0001);
        end_test(30);

        // asleep poke: two-cycle stress_inc; asleep decay gives stress_dec only
        asleep = 1'b1; ind = 2'd2;
        do_reset();
        wait_cyc(1); stim = 4'b0100;
        push(8, 4'b1000); push(9, 4'b1000); push(19, 4'b0100);
        end_test(25);

        // asleep feed: discarded and counted
        ind = 2'd0;
        do_reset();
        wait_cyc(1); stim = 4'b0010;
        wait_cyc(7);
        check("sleep_feed_drop0", 32'(drop_count), 32'h0);
        wait_cyc(9);
        check("sleep_feed_drop1", 32'(drop_count), 32'h1);
        end_test(20);

        // reset during APPLY2 clears stress_inc at once, nothing afterwards
        do_reset();
        wait_cyc(1); stim = 4'b0100;
        push(8, 4'b1000); push(9, 4'b1000);
        wait_cyc(9);
        #2 rst_n = 1'b0; stim = 4'b0000;
        #1 check("async_rst_sinc", 32'(stress_inc), 32'h0);
        check("burst_consumed", 32'(sb.size()), 32'h0);
        do_reset();
        end_test(12);
        check("post_rst_drop", 32'(drop_count), 32'h0);

        // overflow: pet stays pending behind noise and poke, two re-rises dropped
        asleep = 1'b0;
        do_reset();
        wait_cyc(1);  stim = 4'b1101;
        push(8, 4'b1001); push(18, 4'b1000); push(28, 4'b0110); push(38, 4'b0001);
        wait_cyc(6);  stim = 4'b1100;
        wait_cyc(11); stim = 4'b1101;
        wait_cyc(16); stim = 4'b1100;
        wait_cyc(21); stim = 4'b1101;
        wait_cyc(26); stim = 4'b1100;
        wait_cyc(30);
        check("overflow_drop", 32'(drop_count), 32'h2);
        end_test(42);

        // saturation: asleep pet+feed rises, two drops per period
        asleep = 1'b1;
        do_reset();
        for (int p = 0; p < 12; p++) begin
            wait_cyc(1 + 10 * p);
            if (p == 5) check("sat_drop10", 32'(drop_count), 32'd10);
            if (p == 7) check("sat_drop14", 32'(drop_count), 32'd14);
            if (p == 8) check("sat_drop15a", 32'(drop_count), 32'd15);
            stim = 4'b0011;
            wait_cyc(6 + 10 * p);
            stim = 4'b0000;
        end
        wait_cyc(125);
        check("sat_drop15", 32'(drop_count), 32'd15);
        end_test(130);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
